// File: rtl/frame_capture_buffer.sv
// frame_capture_buffer
// Arms on a capture trigger, records the next complete frame of decoded pixels
// into on-chip RAM, then streams that frame out in raster order over a
// valid/ready interface so a stalling consumer never loses video.

module frame_capture_buffer #(
   parameter int FRAME_W = 64,
   parameter int FRAME_H = 48,
   parameter int ADDR_W  = 12
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_capture_trigger,
   input  logic       frame_start,
   input  logic [7:0] decoded_video,
   input  logic       pixel_valid,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last,
   output logic       capture_busy,
   output logic       capture_done,
   output logic       err_short_frame
);

   localparam int PIXELS = FRAME_W * FRAME_H;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      CAPTURE,
      READOUT
   } state_t;

   state_t state;
   state_t next_state;

   logic [7:0]        mem [PIXELS];
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_all_issued;
   logic [7:0]        rd_data;
   logic              pre_valid;
   logic              pre_last;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_index;
   logic              advance;
   logic              issue;
   logic              last_accept;

   // Datapath control: a restart frame_start redirects the coincident pixel to
   // address 0, and the whole read pipeline moves only when the output slot frees.
   always_comb begin
      wr_en       = (state == CAPTURE) && pixel_valid;
      wr_index    = frame_start ? '0 : wr_addr;
      advance     = !out_valid || out_ready;
      issue       = (state == READOUT) && !rd_all_issued && advance;
      last_accept = out_valid && out_ready && out_last;
   end

   assign capture_done = last_accept;

   // Next-state logic; triggers outside IDLE simply fall through and are lost.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (frame_capture_trigger) next_state = ARMED;
         ARMED:   if (frame_start) next_state = CAPTURE;
         CAPTURE: if (pixel_valid && !frame_start && (wr_addr == LAST_ADDR))
                     next_state = READOUT;
         READOUT: if (last_accept) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // State register, with busy registered alongside it so it is glitch-free.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         capture_busy <= 1'b0;
      end else begin
         state        <= next_state;
         capture_busy <= (next_state != IDLE);
      end
   end

   // Write address: cleared at frame start, restarted on a premature frame_start,
   // and parked on the final address rather than wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_addr <= '0;
      end else if (state == ARMED) begin
         if (frame_start) wr_addr <= '0;
      end else if (state == CAPTURE) begin
         if (frame_start)
            wr_addr <= pixel_valid ? ADDR_W'(1) : '0;
         else if (pixel_valid && (wr_addr != LAST_ADDR))
            wr_addr <= wr_addr + ADDR_W'(1);
      end
   end

   // Sticky flag for a frame that restarted before it was complete.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         err_short_frame <= 1'b0;
      else if ((state == CAPTURE) && frame_start)
         err_short_frame <= 1'b1;
   end

   // Frame RAM write port; contents need no reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_index] <= decoded_video;
   end

   // Frame RAM synchronous read port, enabled only when the pipeline advances.
   always_ff @(posedge clk) begin
      if (issue) rd_data <= mem[rd_addr];
   end

   // Read address sequencing: walks 0..last once per READOUT and then stops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_addr       <= '0;
         rd_all_issued <= 1'b0;
      end else if (state != READOUT) begin
         rd_addr       <= '0;
         rd_all_issued <= 1'b0;
      end else if (issue) begin
         if (rd_addr == LAST_ADDR)
            rd_all_issued <= 1'b1;
         else
            rd_addr <= rd_addr + ADDR_W'(1);
      end
   end

   // Tracks which RAM output is valid and whether it carries the final pixel.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_valid <= 1'b0;
         pre_last  <= 1'b0;
      end else if (advance) begin
         pre_valid <= issue;
         pre_last  <= issue && (rd_addr == LAST_ADDR);
      end
   end

   // Output register: holds steady under backpressure, refills every cycle otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
      end else if (advance) begin
         out_valid <= pre_valid;
         out_last  <= pre_valid && pre_last;
         if (pre_valid) out_data <= rd_data;
      end
   end

endmodule

// File: tb/tb_frame_capture_buffer.sv
// Testbench for frame_capture_buffer: a scoreboard queue of expected pixels is
// filled as frames are driven and drained as the DUT hands pixels out.

module tb_frame_capture_buffer;

   localparam int PIXELS = 64 * 48;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       frame_capture_trigger = 1'b0;
   logic       frame_start = 1'b0;
   logic [7:0] decoded_video = 8'h00;
   logic       pixel_valid = 1'b0;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic       out_last;
   logic       capture_busy;
   logic       capture_done;
   logic       err_short_frame;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } exp_t;

   exp_t sb[$];

   int total = 0;
   int bad = 0;
   int out_count = 0;
   int done_count = 0;
   int last_count = 0;
   int valid_seen = 0;
   int stall_count = 0;

   logic       prev_stall = 1'b0;
   logic [7:0] prev_data = 8'h00;
   logic       prev_last = 1'b0;

   frame_capture_buffer dut (
      .clk                   (clk),
      .reset                 (reset),
      .frame_capture_trigger (frame_capture_trigger),
      .frame_start           (frame_start),
      .decoded_video         (decoded_video),
      .pixel_valid           (pixel_valid),
      .out_data              (out_data),
      .out_valid             (out_valid),
      .out_ready             (out_ready),
      .out_last              (out_last),
      .capture_busy          (capture_busy),
      .capture_done          (capture_done),
      .err_short_frame       (err_short_frame)
   );

   // 100 MHz-style free-running clock.
   always #5 clk = ~clk;

   // Output monitor: scoreboard pops on each handshake plus a hold check on stalls.
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (out_valid === 1'b1) valid_seen++;
         if (capture_done === 1'b1) done_count++;
         if (prev_stall) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
               bad++;
               $display("[TB] FAIL stall_hold: got valid=%b data=%02h last=%b, need valid=1 data=%02h last=%b",
                        out_valid, out_data, out_last, prev_data, prev_last);
            end
         end
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            out_count++;
            if (out_last === 1'b1) last_count++;
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("[TB] FAIL unexpected_output: got data=%02h last=%b, need no output", out_data, out_last);
            end else begin
               e = sb.pop_front();
               if (out_data !== e.data || out_last !== e.last || capture_done !== e.last) begin
                  bad++;
                  $display("[TB] FAIL pixel_%0d: got data=%02h last=%b done=%b, need data=%02h last=%b done=%b",
                           out_count - 1, out_data, out_last, capture_done, e.data, e.last, e.last);
               end
            end
         end
         if (out_valid === 1'b1 && out_ready === 1'b0) stall_count++;
         prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
         prev_data  = out_data;
         prev_last  = out_last;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_counts();
      out_count   = 0;
      done_count  = 0;
      last_count  = 0;
      valid_seen  = 0;
      stall_count = 0;
   endtask

   task automatic pulse_trigger();
      frame_capture_trigger = 1'b1;
      tick();
      frame_capture_trigger = 1'b0;
   endtask

   // Drives frame_start then one frame of pixels (k + seed). With restart_after > 0,
   // that many junk pixels go first and the restart frame_start coincides with pixel 0.
   task automatic capture_frame(input int restart_after, input int trig_at, input logic [7:0] seed);
      exp_t e;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      if (restart_after > 0) begin
         for (int k = 0; k < restart_after; k++) begin
            pixel_valid   = 1'b1;
            decoded_video = 8'(k) ^ 8'hA5;
            tick();
         end
         frame_start = 1'b1;
      end
      for (int k = 0; k < PIXELS; k++) begin
         pixel_valid   = 1'b1;
         decoded_video = 8'(k) + seed;
         if (k == trig_at) frame_capture_trigger = 1'b1;
         e.data = 8'(k) + seed;
         e.last = (k == PIXELS - 1);
         sb.push_back(e);
         tick();
         frame_start           = 1'b0;
         frame_capture_trigger = 1'b0;
      end
      pixel_valid = 1'b0;
   endtask

   // Runs until the DUT returns to idle, optionally toggling ready or poking a trigger.
   task automatic wait_idle(input bit toggle, input bit trig_mid, input int budget, output bit timed_out);
      timed_out = 1'b1;
      for (int c = 0; c < budget; c++) begin
         if (toggle) out_ready = ~out_ready;
         if (trig_mid && c == 500) frame_capture_trigger = 1'b1;
         tick();
         frame_capture_trigger = 1'b0;
         if (capture_busy === 1'b0) begin
            timed_out = 1'b0;
            break;
         end
      end
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #12;
      total++;
      if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 8'h00) begin
         bad++;
         $display("[TB] FAIL reset_outputs: got valid=%b last=%b data=%02h, need 0 0 00", out_valid, out_last, out_data);
      end
      total++;
      if (capture_busy !== 1'b0 || capture_done !== 1'b0 || err_short_frame !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_flags: got busy=%b done=%b err=%b, need 0 0 0", capture_busy, capture_done, err_short_frame);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_full_frame();
      bit to;
      clear_counts();
      out_ready = 1'b1;
      pulse_trigger();
      total++;
      if (capture_busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL t1_armed_busy: got %b need 1", capture_busy);
      end
      capture_frame(0, -1, 8'h00);
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL t1_latency_c1: got valid=%b need 0", out_valid);
      end
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL t1_latency_c2: got valid=%b need 0", out_valid);
      end
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1) begin
         bad++;
         $display("[TB] FAIL t1_latency_c3: got valid=%b need 1", out_valid);
      end
      @(posedge clk);
      #1;
      wait_idle(1'b0, 1'b0, 8000, to);
      total++;
      if (to || out_count !== PIXELS || sb.size() != 0) begin
         bad++;
         $display("[TB] FAIL t1_frame: got timeout=%b count=%0d left=%0d, need 0 %0d 0", to, out_count, sb.size(), PIXELS);
      end
      total++;
      if (last_count !== 1 || done_count !== 1) begin
         bad++;
         $display("[TB] FAIL t1_last_done: got last=%0d done=%0d, need 1 1", last_count, done_count);
      end
      tick();
      total++;
      if (capture_busy !== 1'b0 || out_valid !== 1'b0 || err_short_frame !== 1'b0) begin
         bad++;
         $display("[TB] FAIL t1_idle: got busy=%b valid=%b err=%b, need 0 0 0", capture_busy, out_valid, err_short_frame);
      end
   endtask

   task automatic test_stall();
      bit to;
      clear_counts();
      pulse_trigger();
      capture_frame(0, -1, 8'h00);
      wait_idle(1'b1, 1'b0, 12000, to);
      total++;
      if (to || out_count !== PIXELS || sb.size() != 0) begin
         bad++;
         $display("[TB] FAIL t2_frame: got timeout=%b count=%0d left=%0d, need 0 %0d 0", to, out_count, sb.size(), PIXELS);
      end
      total++;
      if (stall_count < 1000 || done_count !== 1 || last_count !== 1) begin
         bad++;
         $display("[TB] FAIL t2_stalls: got stalls=%0d done=%0d last=%0d, need >=1000 1 1", stall_count, done_count, last_count);
      end
   endtask

   task automatic test_armed_hold();
      clear_counts();
      for (int k = 0; k < 20; k++) begin
         pixel_valid   = k[0];
         decoded_video = 8'($urandom_range(0, 255));
         tick();
      end
      pixel_valid = 1'b0;
      total++;
      if (capture_busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL t3_idle_busy: got %b need 0", capture_busy);
      end
      pulse_trigger();
      for (int k = 0; k < 5000; k++) begin
         pixel_valid   = ($urandom_range(0, 3) == 0);
         decoded_video = 8'($urandom_range(0, 255));
         tick();
      end
      pixel_valid = 1'b0;
      total++;
      if (valid_seen !== 0 || out_count !== 0) begin
         bad++;
         $display("[TB] FAIL t3_no_output: got valid_cycles=%0d outputs=%0d, need 0 0", valid_seen, out_count);
      end
      total++;
      if (capture_busy !== 1'b1 || err_short_frame !== 1'b0) begin
         bad++;
         $display("[TB] FAIL t3_armed: got busy=%b err=%b, need 1 0", capture_busy, err_short_frame);
      end
      reset = 1'b1;
      #2;
      total++;
      if (capture_busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL t3_async_reset: got busy=%b need 0", capture_busy);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_short_frame();
      bit to;
      clear_counts();
      pulse_trigger();
      total++;
      if (err_short_frame !== 1'b0) begin
         bad++;
         $display("[TB] FAIL t4_err_before: got %b need 0", err_short_frame);
      end
      capture_frame(100, -1, 8'h40);
      total++;
      if (err_short_frame !== 1'b1) begin
         bad++;
         $display("[TB] FAIL t4_err_set: got %b need 1", err_short_frame);
      end
      wait_idle(1'b0, 1'b0, 8000, to);
      total++;
      if (to || out_count !== PIXELS || sb.size() != 0 || done_count !== 1) begin
         bad++;
         $display("[TB] FAIL t4_frame: got timeout=%b count=%0d left=%0d done=%0d, need 0 %0d 0 1",
                  to, out_count, sb.size(), done_count, PIXELS);
      end
      total++;
      if (err_short_frame !== 1'b1) begin
         bad++;
         $display("[TB] FAIL t4_err_sticky: got %b need 1", err_short_frame);
      end
   endtask

   task automatic test_back_to_back();
      bit to;
      clear_counts();
      pulse_trigger();
      capture_frame(0, 1000, 8'h17);
      wait_idle(1'b0, 1'b1, 8000, to);
      total++;
      if (to || out_count !== PIXELS || sb.size() != 0 || done_count !== 1) begin
         bad++;
         $display("[TB] FAIL t5_frame: got timeout=%b count=%0d left=%0d done=%0d, need 0 %0d 0 1",
                  to, out_count, sb.size(), done_count, PIXELS);
      end
      for (int k = 0; k < 20; k++) tick();
      total++;
      if (capture_busy !== 1'b0 || out_count !== PIXELS) begin
         bad++;
         $display("[TB] FAIL t5_no_rearm: got busy=%b count=%0d, need 0 %0d", capture_busy, out_count, PIXELS);
      end
   endtask

   task automatic test_reset_readout();
      bit to;
      int c;
      clear_counts();
      pulse_trigger();
      capture_frame(0, -1, 8'h33);
      c = 0;
      while (out_count < 1500 && c < 4000) begin
         tick();
         c++;
      end
      total++;
      if (out_count < 1500) begin
         bad++;
         $display("[TB] FAIL t6_reach_1500: got count=%0d need 1500", out_count);
      end
      #2;
      reset = 1'b1;
      #1;
      total++;
      if (out_valid !== 1'b0 || out_last !== 1'b0 || capture_done !== 1'b0) begin
         bad++;
         $display("[TB] FAIL t6_abort_outputs: got valid=%b last=%b done=%b, need 0 0 0", out_valid, out_last, capture_done);
      end
      total++;
      if (capture_busy !== 1'b0 || err_short_frame !== 1'b0) begin
         bad++;
         $display("[TB] FAIL t6_abort_flags: got busy=%b err=%b, need 0 0", capture_busy, err_short_frame);
      end
      sb.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick();
      clear_counts();
      pulse_trigger();
      capture_frame(0, -1, 8'h5C);
      wait_idle(1'b0, 1'b0, 8000, to);
      total++;
      if (to || out_count !== PIXELS || sb.size() != 0 || done_count !== 1 || last_count !== 1) begin
         bad++;
         $display("[TB] FAIL t6_new_frame: got timeout=%b count=%0d left=%0d done=%0d last=%0d, need 0 %0d 0 1 1",
                  to, out_count, sb.size(), done_count, last_count, PIXELS);
      end
   endtask

   // Runs the scenarios in order, then reports.
   initial begin
      test_reset();
      test_full_frame();
      test_stall();
      test_armed_hold();
      test_short_frame();
      test_back_to_back();
      test_reset_readout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
